bist_march_engine: RTL
======================

Name: bist_march_engine

Overview:
Built-in self-test sequencer that sits directly upstream of the MEMCTRL SRAM port mux. While BIST_EN is high, MEMCTRL selects this block's MEM_* bus instead of the host ADDR/IDATA/CE/CSB/OEB/WEB. The block runs one of three one-hot-selected test algorithms, compares each read result against its expected value, and reports BIST_DONE, BIST_PASS and the first failing address.

Parameters:
ADDR_W, 16, memory address width
DATA_W, 8, memory data width
DEPTH, 16, number of words tested, addresses 0..DEPTH-1; must satisfy 2 <= DEPTH <= 2**ADDR_W

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous reset, active-high
BIST_EN  input  1  level; high = run/hold result, low = abort/idle
BIST_MODE  input  3  001 March C-, 010 checkerboard, 100 address-in-data; sampled at start only
MEM_CE  output  1  access strobe to MEMCTRL
MEM_CSB  output  1  chip select, active-low
MEM_WEB  output  1  write enable, active-low
MEM_OEB  output  1  output enable, active-low
MEM_ADDR  output  ADDR_W  access address
MEM_WDATA  output  DATA_W  write data
MEM_RDATA  input  DATA_W  read data from MEMCTRL
BIST_DONE  output  1  run finished; held until BIST_EN low
BIST_PASS  output  1  valid only while BIST_DONE=1, otherwise 0
FAIL_ADDR  output  ADDR_W  address of first mismatch; 0 if none

Behaviour:
- Reset and IDLE output values: MEM_CE=0, MEM_CSB=1, MEM_WEB=1, MEM_OEB=1, MEM_ADDR=0, MEM_WDATA=0, BIST_DONE=0, BIST_PASS=0, FAIL_ADDR=0, internal fail flag=0.
- States: IDLE, ACCESS, RECOVER, DONE.
- IDLE -> ACCESS when BIST_EN=1 is sampled. BIST_MODE is latched on the same edge, and FAIL_ADDR and the fail flag are cleared.
- Every operation takes 2 cycles:
  - ACCESS cycle: CE=1, CSB=0. Write: WEB=0, OEB=1, WDATA=pattern. Read: WEB=1, OEB=0, WDATA=0.
  - RECOVER cycle: CE=0, CSB=1, WEB=1. OEB stays 0 after a read, else 1. For a read, MEM_RDATA is sampled and compared at the end of this cycle.
- After RECOVER, advance op, then element, then address. The next ACCESS follows RECOVER immediately, with no idle gaps.
- Address order:
  - Up-elements run 0..DEPTH-1.
  - Down-elements run DEPTH-1..0.
  - Wrap is detected by an explicit compare against the terminal address, never by counter overflow.
- Mode 001, March C-: up(w0); up(r0,w1); up(r1,w0); down(r0,w1); down(r1,w0); down(r0). Here 0 = all-zeros and 1 = all-ones data. 10 ops per address.
- Mode 010, checkerboard: up(w P); up(r P); up(w ~P); up(r ~P). P = 8'h55 when addr[0]=0 and 8'hAA when addr[0]=1, replicated to DATA_W. 4 ops per address.
- Mode 100, address-in-data: up(w A); up(r A). A = addr[DATA_W-1:0] XOR (addr>>DATA_W)[DATA_W-1:0]. 2 ops per address.
- Latency: BIST_DONE rises exactly 2*ops*DEPTH+1 cycles after the edge on which BIST_EN is first sampled high.
- Mismatch handling: on the first mismatch, FAIL_ADDR is loaded with the read address and the fail flag is set. Later mismatches do not update FAIL_ADDR. The run continues.
- DONE: BIST_DONE=1, BIST_PASS = not fail flag, MEM bus at idle values. The block stays in DONE while BIST_EN=1, so no re-run occurs.
- Invalid mode (not exactly one bit set): the block goes straight to DONE on the next edge with BIST_PASS=0, FAIL_ADDR=0, and issues no memory access.
- BIST_EN=0 in any state: next edge goes to IDLE with all outputs at reset values, including clearing DONE, PASS and FAIL_ADDR. An abort mid-operation drives CSB=1 on the following cycle, so the interrupted access is not completed.
- RST=1 overrides BIST_EN on the same edge.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- With the macro defined: the first mismatch forces DONE on the next edge. BIST_PASS=0, FAIL_ADDR is held, and no further accesses are issued.
- Without the macro: the run always completes the full algorithm, and the DONE timing follows the latency formula regardless of failures.

Test Plan:
- Fault-free memory model, DEPTH=16, mode 001 -> BIST_DONE rises 321 cycles after start; BIST_PASS=1; FAIL_ADDR=0; exactly 160 accesses with CSB=0.
- Fault-free model, mode 010 -> DONE after 129 cycles, PASS=1; write data at addr 0 is 8'h55 and at addr 1 is 8'hAA; addr 3 sees 8'h55 in the inverse pass.
- Model with stuck-at-1 on bit 0 at address 5, mode 100 -> PASS=0, FAIL_ADDR=5, DONE after 65 cycles. With BIST_STOP_ON_FAIL_EN, mode 001 on the same model -> DONE 2 cycles after the first read of addr 5 (r0 in element 2); no CSB=0 afterwards.
- BIST_EN dropped at cycle 50 of mode 001, held low 4 cycles, then raised with mode 010 -> idle bus and DONE=0 during the low period; fresh run completes with PASS=1 at 129 cycles.
- BIST_MODE=3'b011 -> DONE=1 and PASS=0 on the 2nd edge after start, no accesses. RST asserted mid-run -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/bist_march_engine.sv
`default_nettype none
// ============================================================================
// Module      : bist_march_engine
// Description : SRAM built-in self-test sequencer. Runs March C-, checkerboard
//               or address-in-data over words 0..DEPTH-1, one access every two
//               cycles, and reports done/pass plus the first failing address.
//               Optional macro BIST_STOP_ON_FAIL_EN ends the run at the first
//               mismatch instead of completing the algorithm.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_march_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BIST_EN,
    input  logic [2:0]        BIST_MODE,
    output logic              MEM_CE,
    output logic              MEM_CSB,
    output logic              MEM_WEB,
    output logic              MEM_OEB,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BIST_DONE,
    output logic              BIST_PASS,
    output logic [ADDR_W-1:0] FAIL_ADDR
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE   = ADDR_W'(1);
    localparam logic [2:0]        c_MODE_MARCH = 3'b001;
    localparam logic [2:0]        c_MODE_CB    = 3'b010;
    localparam logic [2:0]        c_MODE_AID   = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_mode;
    logic [2:0]        r_elem;
    logic              r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_fail_addr;
    logic              r_fail;
    logic              r_done;
    logic              r_pass;

    logic              w_mode_ok;
    logic              w_is_read;
    logic              w_last_op;
    logic              w_last_elem;
    logic              w_down;
    logic              w_next_down;
    logic              w_mismatch;
    logic              w_run_end;
    logic [DATA_W-1:0] w_pat;
    logic [DATA_W-1:0] w_cb;
    logic [DATA_W-1:0] w_aid;
    logic [ADDR_W-1:0] w_term;

    assign w_mode_ok = (BIST_MODE == c_MODE_MARCH) || (BIST_MODE == c_MODE_CB) ||
                       (BIST_MODE == c_MODE_AID);

    // Address-folded data word: low data-width slice XOR the next slice up.
    assign w_aid = DATA_W'(r_addr) ^ DATA_W'(r_addr >> DATA_W);

    // Checkerboard word: 0x55.. on even addresses, 0xAA.. on odd ones.
    always_comb begin
        w_cb = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_cb[i] = ((i % 2) == 0) ^ r_addr[0];
        end
    end

    // Algorithm decode: operation type, data and element boundaries for the current step.
    always_comb begin
        w_is_read   = 1'b0;
        w_last_op   = 1'b1;
        w_last_elem = 1'b1;
        w_down      = 1'b0;
        w_next_down = 1'b0;
        w_pat       = '0;
        case (r_mode)
            c_MODE_MARCH: begin
                w_last_elem = (r_elem == 3'd5);
                w_last_op   = (r_elem == 3'd0 || r_elem == 3'd5) ? 1'b1 : r_op;
                w_is_read   = (r_elem != 3'd0) && !r_op;
                w_down      = (r_elem >= 3'd3);
                w_next_down = (r_elem >= 3'd2);
                // Elements 2 and 4 read ones; the trailing write flips what was read.
                w_pat       = {DATA_W{(r_elem == 3'd2 || r_elem == 3'd4) ^ r_op}};
            end
            c_MODE_CB: begin
                w_last_elem = (r_elem == 3'd3);
                w_is_read   = r_elem[0];
                w_pat       = w_cb ^ {DATA_W{r_elem[1]}};
            end
            c_MODE_AID: begin
                w_last_elem = (r_elem == 3'd1);
                w_is_read   = r_elem[0];
                w_pat       = w_aid;
            end
            default: ;
        endcase
    end

    assign w_term     = w_down ? '0 : c_LAST_ADDR;
    assign w_mismatch = w_is_read && (MEM_RDATA != w_pat);
    assign w_run_end  = w_last_op && (r_addr == w_term) && w_last_elem;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; dropping BIST_EN always returns to IDLE.
    always_comb begin
        w_next = r_state;
        if (!BIST_EN) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next = w_mode_ok ? S_ACCESS : S_DONE;
                S_ACCESS:  w_next = S_RECOVER;
                S_RECOVER: begin
`ifdef BIST_STOP_ON_FAIL_EN
                    if (w_mismatch) begin
                        w_next = S_DONE;
                    end else
`endif
                    if (w_run_end) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ACCESS;
                    end
                end
                S_DONE:    w_next = S_DONE;
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // Sequencer counters, result capture and status flags.
    always_ff @(posedge CLK) begin
        if (RST || !BIST_EN) begin
            r_mode      <= '0;
            r_elem      <= '0;
            r_op        <= 1'b0;
            r_addr      <= '0;
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_mode      <= BIST_MODE;
                    r_elem      <= '0;
                    r_op        <= 1'b0;
                    r_addr      <= '0;
                    // An unrunnable mode is reported as a failure with no address.
                    r_fail      <= !w_mode_ok;
                    r_fail_addr <= '0;
                    r_done      <= 1'b0;
                    r_pass      <= 1'b0;
                end
                S_RECOVER: begin
                    if (w_mismatch && !r_fail) begin
                        r_fail      <= 1'b1;
                        r_fail_addr <= r_addr;
                    end
                    if (!w_last_op) begin
                        r_op <= 1'b1;
                    end else begin
                        r_op <= 1'b0;
                        if (r_addr != w_term) begin
                            r_addr <= w_down ? (r_addr - c_ADDR_ONE) : (r_addr + c_ADDR_ONE);
                        end else if (!w_last_elem) begin
                            r_elem <= r_elem + 3'd1;
                            r_addr <= w_next_down ? c_LAST_ADDR : '0;
                        end
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= !r_fail;
                end
                default: ;
            endcase
        end
    end

    assign MEM_CE    = (r_state == S_ACCESS);
    assign MEM_CSB   = (r_state != S_ACCESS);
    assign MEM_WEB   = !((r_state == S_ACCESS) && !w_is_read);
    assign MEM_OEB   = !(((r_state == S_ACCESS) || (r_state == S_RECOVER)) && w_is_read);
    assign MEM_ADDR  = ((r_state == S_ACCESS) || (r_state == S_RECOVER)) ? r_addr : '0;
    assign MEM_WDATA = ((r_state == S_ACCESS) && !w_is_read) ? w_pat : '0;
    assign BIST_DONE = r_done;
    assign BIST_PASS = r_pass;
    assign FAIL_ADDR = r_fail_addr;

endmodule
`default_nettype wire
